// File: rtl/timer_cmp_pwm.sv
// Compare-based PWM slaved to an external down counter, with one-shot repeat and sticky irq.
// Define TIMER_CMP_PWM_DEADTIME_EN to add a complementary pwm_n output with dead-time insertion.
//
// state | meaning
// IDLE  | stopped, output parked at pol_sh
// ARMED | started, waiting for the first period boundary
// RUN   | generating PWM from counter vs cmp_sh
// HALT  | one-shot finished, output parked at pol_sh
module timer_cmp_pwm #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] counter,
  input  logic             upd,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] cmp,
  input  logic             pol,
  input  logic             oneshot,
  input  logic [7:0]       rep,
  input  logic [3:0]       dt,
  input  logic             irq_clr,
  output logic             pwm,
  output logic             pwm_n,
  output logic             busy,
  output logic             irq
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, HALT} state_t;

  state_t           state;
  logic [WIDTH-1:0] cmp_sh;
  logic             pol_sh;
  logic [7:0]       rep_cnt;
  logic             raw;

  assign raw = (state == RUN) ? ((counter < cmp_sh) ^ pol_sh) : pol_sh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cmp_sh  <= '0;
      pol_sh  <= 1'b0;
      rep_cnt <= '0;
      busy    <= 1'b0;
      irq     <= 1'b0;
    end else if (en) begin
      // a set later in this block overrides the clear
      if (irq_clr) irq <= 1'b0;
      if (stop) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= ARMED;
              busy  <= 1'b1;
            end
          end
          ARMED: begin
            if (upd) begin
              state   <= RUN;
              cmp_sh  <= cmp;
              pol_sh  <= pol;
              rep_cnt <= rep;
            end
          end
          RUN: begin
            if (upd) begin
              cmp_sh <= cmp;
              pol_sh <= pol;
              if (!oneshot) begin
                irq <= 1'b1;
              end else if (rep_cnt != 8'd0) begin
                rep_cnt <= rep_cnt - 8'd1;
              end else begin
                state <= HALT;
                busy  <= 1'b0;
                irq   <= 1'b1;
              end
            end
          end
          HALT: begin
            if (start) begin
              state <= ARMED;
              busy  <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef TIMER_CMP_PWM_DEADTIME_EN
  logic       tgt;
  logic [3:0] dt_cnt;

  // Any change of raw forces both outputs low and restarts the dead-time window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tgt    <= 1'b0;
      dt_cnt <= '0;
      pwm    <= 1'b0;
      pwm_n  <= 1'b0;
    end else if (en) begin
      if (raw != tgt) begin
        tgt    <= raw;
        dt_cnt <= dt;
        pwm    <= (dt == 4'd0) & raw;
        pwm_n  <= (dt == 4'd0) & ~raw;
      end else if (dt_cnt != 4'd0) begin
        dt_cnt <= dt_cnt - 4'd1;
        if (dt_cnt == 4'd1) begin
          pwm   <= tgt;
          pwm_n <= ~tgt;
        end
      end else begin
        pwm   <= tgt;
        pwm_n <= ~tgt;
      end
    end
  end
`else
  logic unused_dt;
  assign unused_dt = ^dt;
  assign pwm_n     = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pwm <= 1'b0;
    else if (en) pwm <= raw;
  end
`endif

endmodule

// File: doc/timer_cmp_pwm.md
TIMER_CMP_PWM -- requirements
Module: timer_cmp_pwm

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the counter/compare width.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port en  input  1  the block-enable, shared with the upstream down counter.
REQ-005 SHALL have port counter  input  WIDTH  the live value from the upstream down counter.
REQ-006 SHALL have port upd  input  1  the upstream reload event, one pulse per counter period.
REQ-007 SHALL have port start  input  1  the one-cycle request to begin operation.
REQ-008 SHALL have port stop  input  1  the one-cycle request to abort operation.
REQ-009 SHALL have port cmp  input  WIDTH  the compare value, sampled into a shadow register.
REQ-010 SHALL have port pol  input  1  the output polarity, sampled into a shadow register (1 = invert).
REQ-011 SHALL have port oneshot  input  1  the mode select (1 = stop after rep+1 periods).
REQ-012 SHALL have port rep  input  8  the repetition count for one-shot mode.
REQ-013 SHALL have port dt  input  4  the dead-time in clk cycles.
REQ-014 SHALL have port irq_clr  input  1  the one-cycle clear for irq.
REQ-015 SHALL have port pwm  output  1  the registered PWM output.
REQ-016 SHALL have port pwm_n  output  1  the registered complementary PWM output.
REQ-017 SHALL have port busy  output  1  high in states ARMED and RUN.
REQ-018 SHALL have port irq  output  1  the sticky completion flag.

Function
REQ-019 SHALL implement the FSM states IDLE, ARMED, RUN, HALT; the reset state SHALL be IDLE.
REQ-020 IDLE->ARMED on start; ARMED->RUN on upd&en; RUN->HALT when the one-shot repetition count expires; HALT->ARMED on start; any state->IDLE on stop.
REQ-021 In ARMED, on upd&en, SHALL load cmp_sh<=cmp, pol_sh<=pol, and rep_cnt<=rep.
REQ-022 In RUN, on each upd&en, SHALL reload cmp_sh and pol_sh, so that a new cmp takes effect only at a period boundary.
REQ-023 Raw PWM level = (counter < cmp_sh) XOR pol_sh in RUN; pol_sh in all other states.
REQ-024 The raw level SHALL be registered, so pwm lags counter by one cycle.
REQ-025 cmp_sh=0 SHALL give a constant inactive level, and cmp_sh=all-ones SHALL give active except at counter=all-ones.
REQ-026 In RUN with oneshot=1, each upd&en with rep_cnt!=0 SHALL decrement rep_cnt; upd&en with rep_cnt=0 SHALL go to HALT and set irq.
REQ-027 With oneshot=0, rep_cnt SHALL be ignored, RUN SHALL continue until stop, and irq SHALL be set on every upd&en in RUN.
REQ-028 irq SHALL stay set until irq_clr; when set and irq_clr occur in the same cycle, set SHALL win.
REQ-029 When en=0, the FSM and shadow registers SHALL hold, and outputs SHALL hold their last value.
REQ-030 When stop and start occur in the same cycle, stop SHALL win (next state IDLE).
REQ-031 upd in IDLE or HALT SHALL be ignored.

Reset
REQ-032 reset SHALL set: state=IDLE, cmp_sh=0, pol_sh=0, rep_cnt=0, dead-time counter=0, pwm=0, pwm_n=0, busy=0, irq=0.
REQ-033 reset asserted mid-RUN SHALL take effect immediately (asynchronously), and the first active edge after release SHALL evaluate from IDLE.

Configuration
REQ-034 Macro TIMER_CMP_PWM_DEADTIME_EN defined SHALL make pwm_n the complement of pwm, with every rising edge of either output delayed by dt cycles after the other output falls.
REQ-035 With TIMER_CMP_PWM_DEADTIME_EN defined and dt=0, pwm_n SHALL equal ~pwm.
REQ-036 With TIMER_CMP_PWM_DEADTIME_EN defined, a raw level that toggles again within dt cycles SHALL keep both outputs inactive until the raw level is stable for dt cycles.
REQ-037 Macro TIMER_CMP_PWM_DEADTIME_EN undefined SHALL tie pwm_n to 0, ignore dt, and remove the dead-time logic.

Verification
REQ-038 Bench SHALL cover: WIDTH=16, start, upd with cmp=4, counter sweeping 9..0 -> pwm high for counter 3..0, one cycle late; busy=1.
REQ-039 Bench SHALL cover: cmp changed 4->7 mid-period -> duty changes only after the next upd.
REQ-040 Bench SHALL cover: oneshot=1, rep=2 -> exactly 3 full periods, then HALT, irq=1, pwm=pol_sh; irq_clr -> irq=0.
REQ-041 Bench SHALL cover: irq_clr in the same cycle as upd in continuous mode -> irq remains 1.
REQ-042 Bench SHALL cover: start and stop in the same cycle -> IDLE; reset asserted mid-RUN -> all outputs 0 with no clk edge.
REQ-043 Bench SHALL cover: with TIMER_CMP_PWM_DEADTIME_EN and dt=3 -> both outputs low for 3 cycles at each transition; without the macro -> pwm_n stays 0.
